// File: rtl/l2_l1req_arbiter_pkg.sv
// Shared widths and source-tag constants for the L1 request arbiter slice.
// The request/snack layouts mirror I_l1tol2_req_type / I_l2tol1_snack_type.
package l2_l1req_arbiter_pkg;

    localparam int REQ_W      = 36;
    localparam int SNACK_W    = 551;
    localparam int L1ID_W     = 5;
    localparam int L1_SRC_BIT = 4;

    localparam logic L1_SRC_DC = 1'b0;
    localparam logic L1_SRC_IC = 1'b1;

    typedef enum logic {
        SRC_DC = 1'b0,
        SRC_IC = 1'b1
    } l1_src_e;

endpackage

// File: rtl/l2_l1req_prio_sel.sv
// Two-way dcache-priority selector with a bounded-starvation counter for the icache.
// Grants are only issued when the downstream slot can accept a new request.
module l2_l1req_prio_sel
    import l2_l1req_arbiter_pkg::*;
#(
    parameter int MAX_BURST = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic slot_free,
    input  logic dc_valid,
    input  logic ic_valid,
    output logic dc_grant,
    output logic ic_grant
);

    localparam int CNT_W = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(MAX_BURST);

    logic [CNT_W-1:0] burst_cnt_reg;
    logic [CNT_W-1:0] burst_cnt_next;
    logic             ic_due;

    // icache is owed a turn once dcache has won MAX_BURST times in a row against it
    assign ic_due = (burst_cnt_reg == BURST_MAX);

    always_comb begin
        dc_grant = 1'b0;
        ic_grant = 1'b0;
        if (!reset && slot_free) begin
            if (dc_valid && ic_valid) begin
                ic_grant = ic_due;
                dc_grant = !ic_due;
            end else begin
                dc_grant = dc_valid;
                ic_grant = ic_valid;
            end
        end
    end

    always_comb begin
        burst_cnt_next = burst_cnt_reg;
        if (dc_grant) begin
            if (!ic_valid) begin
                burst_cnt_next = '0;
            end else if (!ic_due) begin
                burst_cnt_next = burst_cnt_reg + 1'b1;
            end
        end else if (ic_grant) begin
            burst_cnt_next = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            burst_cnt_reg <= '0;
        end else begin
            burst_cnt_reg <= burst_cnt_next;
        end
    end

endmodule

// File: rtl/l2_l1req_arbiter.sv
// Shares the l1tol2_req / l2tol1_snack port pair between dcache and icache:
// registered request slot tagged with the source in l1id[4], combinational snack steering.
module l2_l1req_arbiter
    import l2_l1req_arbiter_pkg::*;
#(
    parameter int REQ_W     = l2_l1req_arbiter_pkg::REQ_W,
    parameter int SNACK_W   = l2_l1req_arbiter_pkg::SNACK_W,
    parameter int MAX_BURST = 4
) (
    input  logic               clk,
    input  logic               reset,

    input  logic               dc_req_valid,
    output logic               dc_req_retry,
    input  logic [REQ_W-1:0]   dc_req,

    input  logic               ic_req_valid,
    output logic               ic_req_retry,
    input  logic [REQ_W-1:0]   ic_req,

    output logic               l1tol2_req_valid,
    input  logic               l1tol2_req_retry,
    output logic [REQ_W-1:0]   l1tol2_req,

    input  logic               l2tol1_snack_valid,
    output logic               l2tol1_snack_retry,
    input  logic [SNACK_W-1:0] l2tol1_snack,

    output logic               dc_snack_valid,
    input  logic               dc_snack_retry,
    output logic [SNACK_W-1:0] dc_snack,

    output logic               ic_snack_valid,
    input  logic               ic_snack_retry,
    output logic [SNACK_W-1:0] ic_snack
);

    // l1id occupies the top L1ID_W bits of both bundles
    localparam int REQ_SRC_POS   = REQ_W - L1ID_W + L1_SRC_BIT;
    localparam int SNACK_SRC_POS = SNACK_W - L1ID_W + L1_SRC_BIT;

    logic             out_valid_reg;
    logic [REQ_W-1:0] out_data_reg;
    logic             slot_free;
    logic             dc_grant;
    logic             ic_grant;
    logic [REQ_W-1:0] tagged_req;

    assign slot_free = !out_valid_reg || !l1tol2_req_retry;

    l2_l1req_prio_sel #(
        .MAX_BURST (MAX_BURST)
    ) u_prio_sel (
        .clk       (clk),
        .reset     (reset),
        .slot_free (slot_free),
        .dc_valid  (dc_req_valid),
        .ic_valid  (ic_req_valid),
        .dc_grant  (dc_grant),
        .ic_grant  (ic_grant)
    );

    // grants are already suppressed under reset, so retry=1 follows automatically
    assign dc_req_retry = !dc_grant;
    assign ic_req_retry = !ic_grant;

    always_comb begin
        tagged_req              = ic_grant ? ic_req : dc_req;
        tagged_req[REQ_SRC_POS] = ic_grant ? L1_SRC_IC : L1_SRC_DC;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
        end else if (slot_free) begin
            out_valid_reg <= dc_grant || ic_grant;
            if (dc_grant || ic_grant) begin
                out_data_reg <= tagged_req;
            end
        end
    end

    assign l1tol2_req_valid = out_valid_reg;
    assign l1tol2_req       = out_data_reg;

    logic snack_to_ic;
    assign snack_to_ic = l2tol1_snack[SNACK_SRC_POS];

    assign dc_snack_valid     = l2tol1_snack_valid && !snack_to_ic;
    assign ic_snack_valid     = l2tol1_snack_valid && snack_to_ic;
    assign dc_snack           = l2tol1_snack;
    assign ic_snack           = l2tol1_snack;
    assign l2tol1_snack_retry = snack_to_ic ? ic_snack_retry : dc_snack_retry;

endmodule

// File: tb/tb_l2_l1req_arbiter.sv
// Directed bench for l2_l1req_arbiter: reset, solo grant, burst fairness, stall, snack steering, reset mid-stall.
// Inputs change 1ns after the rising edge; outputs are sampled 1ns later or 1ns after the next edge.
module tb_l2_l1req_arbiter;

    localparam int REQ_W     = 36;
    localparam int SNACK_W   = 551;
    localparam int MAX_BURST = 4;

    logic               clk;
    logic               reset;
    logic               dc_req_valid, dc_req_retry;
    logic [REQ_W-1:0]   dc_req;
    logic               ic_req_valid, ic_req_retry;
    logic [REQ_W-1:0]   ic_req;
    logic               l1tol2_req_valid, l1tol2_req_retry;
    logic [REQ_W-1:0]   l1tol2_req;
    logic               l2tol1_snack_valid, l2tol1_snack_retry;
    logic [SNACK_W-1:0] l2tol1_snack;
    logic               dc_snack_valid, dc_snack_retry;
    logic [SNACK_W-1:0] dc_snack;
    logic               ic_snack_valid, ic_snack_retry;
    logic [SNACK_W-1:0] ic_snack;

    int n_cmp  = 0;
    int n_fail = 0;

    l2_l1req_arbiter #(
        .REQ_W     (REQ_W),
        .SNACK_W   (SNACK_W),
        .MAX_BURST (MAX_BURST)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .dc_req_valid       (dc_req_valid),
        .dc_req_retry       (dc_req_retry),
        .dc_req             (dc_req),
        .ic_req_valid       (ic_req_valid),
        .ic_req_retry       (ic_req_retry),
        .ic_req             (ic_req),
        .l1tol2_req_valid   (l1tol2_req_valid),
        .l1tol2_req_retry   (l1tol2_req_retry),
        .l1tol2_req         (l1tol2_req),
        .l2tol1_snack_valid (l2tol1_snack_valid),
        .l2tol1_snack_retry (l2tol1_snack_retry),
        .l2tol1_snack       (l2tol1_snack),
        .dc_snack_valid     (dc_snack_valid),
        .dc_snack_retry     (dc_snack_retry),
        .dc_snack           (dc_snack),
        .ic_snack_valid     (ic_snack_valid),
        .ic_snack_retry     (ic_snack_retry),
        .ic_snack           (ic_snack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [SNACK_W-1:0] obs, input logic [SNACK_W-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // hand-computed tagged bundles: l1id[4] is bit 35
    localparam logic [REQ_W-1:0] DC2_IN  = {5'h03, 31'h0ABC_DEF};
    localparam logic [REQ_W-1:0] DC2_EXP = {5'h03, 31'h0ABC_DEF};
    localparam logic [REQ_W-1:0] DC3_IN  = {5'h1F, 31'h1234_567};
    localparam logic [REQ_W-1:0] DC3_EXP = {5'h0F, 31'h1234_567};
    localparam logic [REQ_W-1:0] IC3_IN  = {5'h07, 31'h7654_321};
    localparam logic [REQ_W-1:0] IC3_EXP = {5'h17, 31'h7654_321};

    logic [SNACK_W-1:0] snack_ic_v;
    logic [SNACK_W-1:0] snack_dc_v;
    logic               exp_ic;

    initial begin
        snack_ic_v = {5'h12, 2'b10, {17{32'hDEAD_BEEF}}};
        snack_dc_v = {5'h03, 2'b01, {17{32'h1357_9BDF}}};

        // 1: reset held 3 cycles with all valids high
        reset = 1'b1;
        dc_req_valid = 1'b1; dc_req = DC2_IN;
        ic_req_valid = 1'b1; ic_req = IC3_IN;
        l1tol2_req_retry   = 1'b0;
        l2tol1_snack_valid = 1'b0; l2tol1_snack = '0;
        dc_snack_retry = 1'b0; ic_snack_retry = 1'b0;
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            check("rst_out_valid", SNACK_W'(l1tol2_req_valid), SNACK_W'(1'b0));
            check("rst_dc_retry",  SNACK_W'(dc_req_retry),     SNACK_W'(1'b1));
            check("rst_ic_retry",  SNACK_W'(ic_req_retry),     SNACK_W'(1'b1));
        end

        // 2: solo dcache request
        reset = 1'b0;
        ic_req_valid = 1'b0;
        #1;
        check("solo_dc_retry", SNACK_W'(dc_req_retry), SNACK_W'(1'b0));
        check("solo_ic_retry", SNACK_W'(ic_req_retry), SNACK_W'(1'b1));
        next_cycle();
        $display("grant dc req=%h", l1tol2_req);
        check("solo_out_valid", SNACK_W'(l1tol2_req_valid), SNACK_W'(1'b1));
        check("solo_out_data",  SNACK_W'(l1tol2_req),       SNACK_W'(DC2_EXP));
        dc_req_valid = 1'b0;
        next_cycle();
        check("solo_drain_valid", SNACK_W'(l1tol2_req_valid), SNACK_W'(1'b0));

        // 3: both valid, expect dc,dc,dc,dc,ic repeating
        dc_req_valid = 1'b1; dc_req = DC3_IN;
        ic_req_valid = 1'b1; ic_req = IC3_IN;
        for (int i = 0; i < 10; i++) begin
            exp_ic = ((i % 5) == 4);
            #1;
            check("burst_dc_retry", SNACK_W'(dc_req_retry), SNACK_W'(exp_ic));
            check("burst_ic_retry", SNACK_W'(ic_req_retry), SNACK_W'(!exp_ic));
            next_cycle();
            $display("grant %s req=%h", exp_ic ? "ic" : "dc", l1tol2_req);
            check("burst_out_valid", SNACK_W'(l1tol2_req_valid), SNACK_W'(1'b1));
            check("burst_out_data",  SNACK_W'(l1tol2_req), exp_ic ? SNACK_W'(IC3_EXP) : SNACK_W'(DC3_EXP));
        end

        // 4: downstream stall for 5 cycles with the icache request held
        l1tol2_req_retry = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("stall_dc_retry", SNACK_W'(dc_req_retry), SNACK_W'(1'b1));
            check("stall_ic_retry", SNACK_W'(ic_req_retry), SNACK_W'(1'b1));
            next_cycle();
            check("stall_out_valid", SNACK_W'(l1tol2_req_valid), SNACK_W'(1'b1));
            check("stall_out_data",  SNACK_W'(l1tol2_req),       SNACK_W'(IC3_EXP));
        end
        l1tol2_req_retry = 1'b0;
        #1;
        check("unstall_dc_retry", SNACK_W'(dc_req_retry), SNACK_W'(1'b0));
        check("unstall_ic_retry", SNACK_W'(ic_req_retry), SNACK_W'(1'b1));
        next_cycle();
        $display("grant dc req=%h", l1tol2_req);
        check("unstall_out_valid", SNACK_W'(l1tol2_req_valid), SNACK_W'(1'b1));
        check("unstall_out_data",  SNACK_W'(l1tol2_req),       SNACK_W'(DC3_EXP));

        // 5: snack steering to icache (stalled) and to dcache
        ic_req_valid = 1'b0;
        dc_req_valid = 1'b0;
        l2tol1_snack_valid = 1'b1;
        l2tol1_snack   = snack_ic_v;
        ic_snack_retry = 1'b1;
        dc_snack_retry = 1'b0;
        #1;
        check("snk_ic_valid", SNACK_W'(ic_snack_valid),     SNACK_W'(1'b1));
        check("snk_dc_valid", SNACK_W'(dc_snack_valid),     SNACK_W'(1'b0));
        check("snk_ic_retry", SNACK_W'(l2tol1_snack_retry), SNACK_W'(1'b1));
        check("snk_ic_data",  ic_snack,                     snack_ic_v);
        l2tol1_snack = snack_dc_v;
        #1;
        check("snk_dc_valid2", SNACK_W'(dc_snack_valid),     SNACK_W'(1'b1));
        check("snk_ic_valid2", SNACK_W'(ic_snack_valid),     SNACK_W'(1'b0));
        check("snk_dc_retry",  SNACK_W'(l2tol1_snack_retry), SNACK_W'(1'b0));
        check("snk_dc_data",   dc_snack,                     snack_dc_v);
        next_cycle();
        check("idle_out_valid", SNACK_W'(l1tol2_req_valid), SNACK_W'(1'b0));

        // 6: reset while the slot holds a stalled request
        dc_req_valid = 1'b1; dc_req = DC2_IN;
        next_cycle();
        check("pre_rst_valid", SNACK_W'(l1tol2_req_valid), SNACK_W'(1'b1));
        l1tol2_req_retry = 1'b1;
        reset = 1'b1;
        l2tol1_snack = snack_ic_v;
        ic_snack_retry = 1'b0;
        #1;
        check("midrst_dc_retry",  SNACK_W'(dc_req_retry),   SNACK_W'(1'b1));
        check("midrst_snk_valid", SNACK_W'(ic_snack_valid), SNACK_W'(1'b1));
        next_cycle();
        check("midrst_out_valid", SNACK_W'(l1tol2_req_valid), SNACK_W'(1'b0));
        reset = 1'b0;
        l1tol2_req_retry = 1'b0;
        dc_req_valid = 1'b0;
        next_cycle();
        check("postrst_out_valid", SNACK_W'(l1tol2_req_valid), SNACK_W'(1'b0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
